// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, block width, key-size presets,
// GF(2^8) arithmetic and the byte-level round transforms used by the
// cipher, its round datapath and the key schedule.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    // Key length (32-bit words) / round count pairs.
    localparam int AES128_NK = 4;
    localparam int AES128_NR = 10;
    localparam int AES192_NK = 6;
    localparam int AES192_NR = 12;
    localparam int AES256_NK = 8;
    localparam int AES256_NR = 14;

    // Exponent giving the multiplicative inverse in GF(2^8): x^254 = x^-1.
    localparam logic [7:0] GF_INV_EXP = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    // LSB position of round key r inside the expanded key; round 0 sits at
    // the top of the vector, round nr at the bottom.
    function automatic int rk_lsb(input int nr, input int r);
        return AES_BLOCK_W * (nr - r);
    endfunction

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end else begin
                acc = acc;
            end
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    // S-box evaluated arithmetically: field inverse (0 maps to 0) followed by
    // the affine transform, so no 256-entry table has to be maintained.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = x;
        for (int i = 0; i < 8; i++) begin
            if (GF_INV_EXP[i]) begin
                inv = gf_mul(inv, base);
            end else begin
                inv = inv;
            end
            base = gf_mul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte k of the state lives at bits [127-8k -: 8]; column-major order.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8*k -: 8] = sbox(s[127 - 8*k -: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_xtime(a0) ^ gf_xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ gf_xtime(a1) ^ gf_xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ gf_xtime(a2) ^ gf_xtime(a3) ^ a3,
                gf_xtime(a0) ^ a0 ^ a1 ^ a2 ^ gf_xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] rk);
        return s ^ rk;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round. i_final skips MixColumns for the
// last round of the cipher.
module aes_round
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] i_state,
    input  logic [AES_BLOCK_W-1:0] i_round_key,
    input  logic                   i_final,
    output logic [AES_BLOCK_W-1:0] o_state
);

    logic [AES_BLOCK_W-1:0] sb_s;
    logic [AES_BLOCK_W-1:0] sr_s;
    logic [AES_BLOCK_W-1:0] mc_s;

    // SubBytes -> ShiftRows -> (MixColumns) -> AddRoundKey.
    always_comb begin
        sb_s = sub_bytes(i_state);
        sr_s = shift_rows(sb_s);
        mc_s = mix_columns(sr_s);
        if (i_final) begin
            o_state = add_round_key(sr_s, i_round_key);
        end else begin
            o_state = add_round_key(mc_s, i_round_key);
        end
    end

endmodule

// File: rtl/key_expansion.sv
// AES key schedule: expands an NK-word cipher key into 4*(NR+1) words,
// word 0 at the MSB end of the output vector.
module key_expansion
    import aes_pkg::*;
#(
    parameter int NK = AES128_NK,
    parameter int NR = AES128_NR
) (
    input  logic [32*NK-1:0]              i_key,
    output logic [AES_BLOCK_W*(NR+1)-1:0] o_expanded_key
);

    localparam int NW    = 4 * (NR + 1);
    localparam int KEY_W = 32 * NK;
    localparam int EXP_W = AES_BLOCK_W * (NR + 1);

    // Compute every schedule word in order and pack them into the output.
    always_comb begin
        logic [31:0] w [NW];
        logic [31:0] temp;
        logic [7:0]  rcon;
        rcon           = 8'h01;
        temp           = 32'h0000_0000;
        o_expanded_key = '0;
        for (int i = 0; i < NK; i++) begin
            w[i] = i_key[KEY_W - 1 - 32*i -: 32];
        end
        for (int i = NK; i < NW; i++) begin
            temp = w[i - 1];
            if ((i % NK) == 0) begin
                temp = sub_word(rot_word(temp)) ^ {rcon, 24'h00_0000};
                rcon = gf_xtime(rcon);
            end else if ((NK > 6) && ((i % NK) == 4)) begin
                temp = sub_word(temp);
            end else begin
                temp = temp;
            end
            w[i] = w[i - NK] ^ temp;
        end
        for (int i = 0; i < NW; i++) begin
            o_expanded_key[EXP_W - 1 - 32*i -: 32] = w[i];
        end
    end

endmodule

// File: rtl/cipher_iter.sv
// Iterative AES forward cipher: one round per clock on a single state
// register, valid/ready handshakes on the plaintext and ciphertext sides.
module cipher_iter
    import aes_pkg::*;
#(
    parameter int NK = AES128_NK,
    parameter int NR = AES128_NR
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [AES_BLOCK_W-1:0] i_data,
    input  logic [32*NK-1:0]       i_key,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [AES_BLOCK_W-1:0] o_data,
    output logic                   o_busy
);

    localparam int KEY_W = 32 * NK;
    localparam int EXP_W = AES_BLOCK_W * (NR + 1);
    localparam int RCW   = $clog2(NR + 1);
    localparam logic [RCW-1:0] LAST_RND = RCW'(NR);

    aes_state_e             fsm_q,   fsm_d;
    logic [RCW-1:0]         rnd_q,   rnd_d;
    logic [AES_BLOCK_W-1:0] blk_q,   blk_d;
    logic [KEY_W-1:0]       key_q,   key_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic                   busy_q,  busy_d;

    logic [EXP_W-1:0]       key_exp_s;
    logic [AES_BLOCK_W-1:0] rk_s;
    logic [AES_BLOCK_W-1:0] round_s;
    logic                   final_s;

    // The schedule runs from the captured key, so input changes after the
    // accepting edge never reach the datapath.
    key_expansion #(
        .NK (NK),
        .NR (NR)
    ) u_key_expansion (
        .i_key          (key_q),
        .o_expanded_key (key_exp_s)
    );

    // Pick the round key for the current round counter value.
    always_comb begin
        rk_s = '0;
        for (int r = 0; r <= NR; r++) begin
            rk_s = (rnd_q == RCW'(r)) ? key_exp_s[rk_lsb(NR, r) +: AES_BLOCK_W] : rk_s;
        end
    end

    assign final_s = (rnd_q == LAST_RND);

    aes_round u_aes_round (
        .i_state     (blk_q),
        .i_round_key (rk_s),
        .i_final     (final_s),
        .o_state     (round_s)
    );

    // FSM next state, datapath updates and registered output flags.
    always_comb begin
        fsm_d = fsm_q;
        rnd_d = rnd_q;
        blk_d = blk_q;
        key_d = key_q;
        case (fsm_q)
            ST_IDLE: begin
                if (i_valid) begin
                    // rk[0] is simply the first four key words.
                    key_d = i_key;
                    blk_d = add_round_key(i_data, i_key[KEY_W-1 -: AES_BLOCK_W]);
                    rnd_d = RCW'(1);
                    fsm_d = ST_ROUND;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_ROUND: begin
                blk_d = round_s;
                if (final_s) begin
                    rnd_d = '0;
                    fsm_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q + RCW'(1);
                    fsm_d = ST_ROUND;
                end
            end
            ST_DONE: begin
                // Returning to IDLE takes the whole edge; no accept here.
                if (i_ready) begin
                    fsm_d = ST_IDLE;
                end else begin
                    fsm_d = ST_DONE;
                end
            end
            default: begin
                rnd_d = '0;
                fsm_d = ST_IDLE;
            end
        endcase
        ready_d = (fsm_d == ST_IDLE);
        valid_d = (fsm_d == ST_DONE);
        busy_d  = (fsm_d == ST_ROUND);
    end

    // State, key, counter and output flag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q   <= ST_IDLE;
            rnd_q   <= '0;
            blk_q   <= '0;
            key_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_data  = blk_q;

endmodule

// File: tb/tb_cipher_iter.sv
// Directed bench for cipher_iter: FIPS-197 vectors on AES-128/192/256
// instances, backpressure/isolation and asynchronous reset mid-round.
module tb_cipher_iter;

    logic         clk;
    logic         rst_n;
    logic [2:0]   vin;
    logic [2:0]   rin;
    logic [2:0]   ordy;
    logic [2:0]   ov;
    logic [2:0]   obusy;
    logic [127:0] data;
    logic [255:0] key;
    logic [127:0] od [3];

    int n_tests;
    int n_fail;

    typedef struct {
        int           sel;
        int           nr;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    cipher_iter #(.NK(4), .NR(10)) u_aes128 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[0]), .o_ready(ordy[0]),
        .i_data(data), .i_key(key[255:128]), .o_valid(ov[0]), .i_ready(rin[0]),
        .o_data(od[0]), .o_busy(obusy[0]));

    cipher_iter #(.NK(6), .NR(12)) u_aes192 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[1]), .o_ready(ordy[1]),
        .i_data(data), .i_key(key[255:64]), .o_valid(ov[1]), .i_ready(rin[1]),
        .o_data(od[1]), .o_busy(obusy[1]));

    cipher_iter #(.NK(8), .NR(14)) u_aes256 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[2]), .o_ready(ordy[2]),
        .i_data(data), .i_key(key), .o_valid(ov[2]), .i_ready(rin[2]),
        .o_data(od[2]), .o_busy(obusy[2]));

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r = {r[223:0], 32'($urandom())};
        end
        return r;
    endfunction

    // Accept one vector, measure latency, check the result and the return to IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        @(negedge clk);
        rin[v.sel] = 1'b1;
        key        = v.key;
        data       = v.pt;
        vin[v.sel] = 1'b1;
        check_bit({tag, "_ready_idle"}, ordy[v.sel], 1'b1);
        @(posedge clk);
        #1;
        vin[v.sel] = 1'b0;
        check_bit({tag, "_busy"}, obusy[v.sel], 1'b1);
        cyc = 0;
        while (!ov[v.sel] && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_int({tag, "_latency"}, cyc, v.nr);
        check_word({tag, "_ct"}, od[v.sel], v.ct);
        check_bit({tag, "_ready_done"}, ordy[v.sel], 1'b0);
        @(posedge clk);
        #1;
        check_bit({tag, "_valid_drop"}, ov[v.sel], 1'b0);
        check_bit({tag, "_ready_back"}, ordy[v.sel], 1'b1);
    endtask

    initial begin
        int cyc;
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{sel: 0, nr: 10,
                    key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{sel: 0, nr: 10,
                    key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{sel: 1, nr: 12,
                    key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        vecs[3] = '{sel: 2, nr: 14,
                    key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h8ea2b7ca516745bfeafc49904b496089};

        rst_n = 1'b0;
        vin   = 3'b000;
        rin   = 3'b000;
        key   = '0;
        data  = '0;
        #12;
        for (int s = 0; s < 3; s++) begin
            check_bit($sformatf("rst_ready%0d", s), ordy[s], 1'b1);
            check_bit($sformatf("rst_valid%0d", s), ov[s], 1'b0);
            check_bit($sformatf("rst_busy%0d", s), obusy[s], 1'b0);
            check_word($sformatf("rst_data%0d", s), od[s], 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure with inputs toggling and i_valid held high outside IDLE.
        @(negedge clk);
        rin[0] = 1'b0;
        key    = vecs[1].key;
        data   = vecs[1].pt;
        vin[0] = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        while (!ov[0] && cyc < 40) begin
            @(negedge clk);
            key  = rand256();
            data = rand256()[127:0];
            @(posedge clk);
            #1;
            cyc++;
        end
        check_int("bp_latency", cyc, 10);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            key  = rand256();
            data = rand256()[127:0];
            check_bit($sformatf("bp_valid_hold%0d", k), ov[0], 1'b1);
            check_word($sformatf("bp_data_hold%0d", k), od[0], vecs[1].ct);
            check_bit($sformatf("bp_ready_hold%0d", k), ordy[0], 1'b0);
        end
        @(negedge clk);
        rin[0] = 1'b1;
        @(posedge clk);
        #1;
        vin[0] = 1'b0;
        check_bit("bp_release_valid", ov[0], 1'b0);
        check_bit("bp_release_ready", ordy[0], 1'b1);
        check_bit("bp_release_no_accept", obusy[0], 1'b0);
        @(posedge clk);
        #1;
        check_bit("bp_idle_stays", ordy[0], 1'b1);

        // Asynchronous reset while round 5 is being computed.
        @(negedge clk);
        key    = vecs[1].key;
        data   = vecs[1].pt;
        vin[0] = 1'b1;
        @(posedge clk);
        #1;
        vin[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("mid_rst_valid", ov[0], 1'b0);
        check_word("mid_rst_data", od[0], 128'h0);
        check_bit("mid_rst_ready", ordy[0], 1'b1);
        check_bit("mid_rst_busy", obusy[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[1], "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
